mem_port_arbiter: RTL

//  Shares one single-ported backing memory between the fetch stage (I port, read-only) and
//  the memory stage (D port, read/write) of the 5-stage core. Sequences each access through
//  a fixed-latency memory, returns read data with a one-cycle ACK pulse, and prevents fetch

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the fetch (I) and memory-stage (D) ports.
// Define ARB_STATS_EN to add saturating grant/conflict statistics outputs.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        I_REQ,
   input  logic [15:0] I_ADDR,
   output logic        I_ACK,
   output logic [31:0] I_RDATA,
   input  logic        D_REQ,
   input  logic        D_WE,
   input  logic [15:0] D_ADDR,
   input  logic [31:0] D_WDATA,
   input  logic [1:0]  D_SIZE,
   input  logic        D_SIGNED,
   output logic        D_ACK,
   output logic [31:0] D_RDATA,
   output logic        MEM_EN,
   output logic        MEM_WE,
   output logic [15:0] MEM_ADDR,
   output logic [31:0] MEM_WDATA,
   output logic [1:0]  MEM_SIZE,
   output logic        MEM_SIGNED,
   input  logic [31:0] MEM_RDATA,
   output logic        BUSY
`ifdef ARB_STATS_EN
   ,
   output logic [15:0] STAT_I_GNT,
   output logic [15:0] STAT_D_GNT,
   output logic [15:0] STAT_CONFL
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [2:0]  starve_cnt;
   logic        win_d;
   logic        grant_d;

   // D has priority unless fetch has been passed over STARVE_MAX times in a row
   always_comb begin
      grant_d = D_REQ && !(I_REQ && (starve_cnt == 3'(STARVE_MAX)));
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         cnt        <= '0;
         starve_cnt <= '0;
         win_d      <= 1'b0;
         I_ACK      <= 1'b0;
         I_RDATA    <= '0;
         D_ACK      <= 1'b0;
         D_RDATA    <= '0;
         MEM_EN     <= 1'b0;
         MEM_WE     <= 1'b0;
         MEM_ADDR   <= '0;
         MEM_WDATA  <= '0;
         MEM_SIZE   <= '0;
         MEM_SIGNED <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         MEM_EN <= 1'b0;
         case (state)
            IDLE: begin
               if (I_REQ || D_REQ) begin
                  state  <= WAIT;
                  BUSY   <= 1'b1;
                  MEM_EN <= 1'b1;
                  cnt    <= 4'(MEM_LAT - 1);
                  win_d  <= grant_d;
                  if (grant_d) begin
                     MEM_WE     <= D_WE;
                     MEM_ADDR   <= D_ADDR;
                     MEM_WDATA  <= D_WDATA;
                     MEM_SIZE   <= D_SIZE;
                     MEM_SIGNED <= D_SIGNED;
                     if (!I_REQ)
                        starve_cnt <= '0;
                     else if (starve_cnt != 3'd7)
                        starve_cnt <= starve_cnt + 3'd1;
                  end else begin
                     MEM_WE     <= 1'b0;
                     MEM_ADDR   <= I_ADDR;
                     MEM_SIZE   <= 2'd2;
                     MEM_SIGNED <= 1'b0;
                     starve_cnt <= '0;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state <= DONE;
                  if (win_d) begin
                     D_ACK <= 1'b1;
                     if (!MEM_WE)
                        D_RDATA <= MEM_RDATA;
                  end else begin
                     I_ACK   <= 1'b1;
                     I_RDATA <= MEM_RDATA;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               I_ACK <= 1'b0;
               D_ACK <= 1'b0;
               BUSY  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ARB_STATS_EN
   logic gnt_fire;

   always_comb begin
      gnt_fire = (state == IDLE) && (I_REQ || D_REQ);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         STAT_I_GNT <= '0;
         STAT_D_GNT <= '0;
         STAT_CONFL <= '0;
      end else if (gnt_fire) begin
         if (grant_d && (STAT_D_GNT != '1))
            STAT_D_GNT <= STAT_D_GNT + 16'd1;
         if (!grant_d && (STAT_I_GNT != '1))
            STAT_I_GNT <= STAT_I_GNT + 16'd1;
         if (I_REQ && D_REQ && (STAT_CONFL != '1))
            STAT_CONFL <= STAT_CONFL + 16'd1;
      end
   end
`endif

endmodule
